pla_sweep_ctrl: RTL and testbench
=================================

Name: pla_sweep_ctrl

Overview:
Exhaustive sweep controller for the single-output combinational restriction functions in the autosymmetry benchmark set. It drives every input vector 0 .. 2^N_IN-1 into two combinational implementations of the same restriction, the golden PLA-derived netlist and the optimized netlist under test. It samples both outputs after a programmable settle time and accumulates equivalence statistics. It sits on the bench or FPGA side of the flow and gives an on-chip yes/no equivalence verdict plus the ON-set size and the first failing vector.

Parameters:
N_IN, 7, number of primary inputs of the restriction; sweep length 2^N_IN vectors.
SETTLE, 0, extra wait cycles between applying a vector and sampling outputs; legal range 0..15.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; honoured only in IDLE or DONE
abort  input  1  cancel a running sweep
x_out  output  N_IN  input vector driven to both functions (bit i -> xi)
y_ref  input  1  output of golden function for x_out
y_dut  input  1  output of optimized function for x_out
busy  output  1  high while sweep in progress
done  output  1  high in DONE state; results valid
mismatch_cnt  output  N_IN+1  number of vectors with y_ref != y_dut
onset_cnt  output  N_IN+1  number of vectors with y_ref == 1
first_mm_idx  output  N_IN  lowest vector index with a mismatch
first_mm_valid  output  1  at least one mismatch recorded
equal  output  1  done && mismatch_cnt == 0

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered except equal, which is decoded from registers.
- Reset (synchronous, priority over everything): state = IDLE. x_out, mismatch_cnt, onset_cnt, first_mm_idx, first_mm_valid, busy, done and equal all = 0. Wait counter = 0.
- IDLE or DONE with start=1:
  - Next cycle enters RUN with x_out=0.
  - Counters, first_mm_idx and first_mm_valid are cleared.
  - Wait counter is loaded with SETTLE; busy=1 and done=0.
- RUN, wait counter != 0: decrement it. x_out is held.
- RUN, wait counter == 0 (the sample cycle):
  - onset_cnt += y_ref.
  - If y_ref != y_dut: mismatch_cnt += 1. If first_mm_valid=0, then first_mm_idx <= x_out and first_mm_valid <= 1.
  - If x_out == all ones: go to DONE, busy=0, done=1, x_out held.
  - Otherwise: x_out += 1 and wait counter reloads to SETTLE.
- Each vector is presented for exactly SETTLE+1 cycles and sampled in its last cycle.
- A full sweep takes 2^N_IN*(SETTLE+1) RUN cycles. done rises on the next edge after the last sample.
- Counters are N_IN+1 bits wide, so 2^N_IN fits exactly and no saturation is needed.
- DONE: results and done are held until start, abort-independent, or rst. start in DONE restarts the sweep and drops done the next cycle.
- abort=1 in RUN: next cycle state = IDLE, busy=0, done=0, x_out=0. Partial counters are left as-is and are defined invalid (done=0). abort outside RUN is ignored.
- abort and start asserted together in RUN: abort wins. The start is not queued.
- start while in RUN: ignored.
- rst mid-sweep: full reset as above. No residual state survives.
- y_ref and y_dut are assumed stable combinational functions of x_out. The controller does no synchronization on them.

Test Plan:
- N_IN=7, SETTLE=0, y_ref=y_dut=1 constant, pulse start -> busy for 128 cycles, then done=1, onset_cnt=128, mismatch_cnt=0, equal=1, first_mm_valid=0.
- y_ref = x_out[0], y_dut = ~y_ref -> mismatch_cnt=128, first_mm_idx=0, onset_cnt=64, equal=0.
- y_ref = (x_out==7'h7F), y_dut = y_ref except forced 1 at x_out=7'h55 -> mismatch_cnt=1, first_mm_idx=7'h55, onset_cnt=1.
- SETTLE=3, identical functions -> each x_out value held 4 cycles, done asserted 512 cycles after sweep start, counters identical to the SETTLE=0 run.
- Start sweep, assert abort while x_out=40 -> next cycle IDLE, busy=0, done=0, x_out=0. Restart -> full correct results. Same test with rst instead of abort -> all outputs 0.
- start pulsed repeatedly during RUN and together with abort -> no restart, x_out sequence monotonic, abort honoured.

Source files
------------

// File: rtl/pla_sweep_ctrl.sv
// pla_sweep_ctrl: exhaustive input sweep for a pair of single-output
// combinational functions (golden vs. optimized). Each vector is held for
// SETTLE+1 cycles and both outputs are sampled in the last of them; the
// controller accumulates ON-set size, mismatch count and the first failing
// vector, and reports an equivalence verdict when the sweep completes.
module pla_sweep_ctrl #(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] x_out,
    input  logic            y_ref,
    input  logic            y_dut,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN:0]   onset_cnt,
    output logic [N_IN-1:0] first_mm_idx,
    output logic            first_mm_valid,
    output logic            equal
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
    localparam logic [N_IN-1:0] X_LAST    = '1;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_nxt;
    logic [N_IN-1:0]   x_nxt;
    logic [N_IN:0]     mm_nxt, on_nxt;
    logic [N_IN-1:0]   fidx_nxt;
    logic              fvalid_nxt;
    logic              busy_nxt, done_nxt;

    // State and result registers; synchronous reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            x_out          <= '0;
            mismatch_cnt   <= '0;
            onset_cnt      <= '0;
            first_mm_idx   <= '0;
            first_mm_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_nxt;
            x_out          <= x_nxt;
            mismatch_cnt   <= mm_nxt;
            onset_cnt      <= on_nxt;
            first_mm_idx   <= fidx_nxt;
            first_mm_valid <= fvalid_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
        end
    end

    // Next-state, vector stepping and statistics accumulation.
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        x_nxt      = x_out;
        mm_nxt     = mismatch_cnt;
        on_nxt     = onset_cnt;
        fidx_nxt   = first_mm_idx;
        fvalid_nxt = first_mm_valid;
        busy_nxt   = busy;
        done_nxt   = done;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RUN;
                    x_nxt      = '0;
                    mm_nxt     = '0;
                    on_nxt     = '0;
                    fidx_nxt   = '0;
                    fvalid_nxt = 1'b0;
                    wait_nxt   = SETTLE_LD;
                    busy_nxt   = 1'b1;
                    done_nxt   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    // Partial statistics are kept but flagged invalid by done=0.
                    state_nxt = IDLE;
                    x_nxt     = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else if (wait_cnt != '0) begin
                    wait_nxt = wait_cnt - 4'd1;
                end else begin
                    on_nxt = onset_cnt + {{N_IN{1'b0}}, y_ref};
                    if (y_ref != y_dut) begin
                        mm_nxt = mismatch_cnt + {{N_IN{1'b0}}, 1'b1};
                        if (!first_mm_valid) begin
                            fidx_nxt   = x_out;
                            fvalid_nxt = 1'b1;
                        end
                    end
                    if (x_out == X_LAST) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        x_nxt    = x_out + {{(N_IN-1){1'b0}}, 1'b1};
                        wait_nxt = SETTLE_LD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign equal = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb_pla_sweep_ctrl: two controller instances (SETTLE=0 and SETTLE=3) sweep
// truth tables held in the bench; expected statistics come from a direct
// enumeration of the tables, expected timing from the vector hold rule.
module tb_pla_sweep_ctrl;

    localparam int N = 7;
    localparam int V = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_s [2];
    logic         abort_s [2];
    logic [N-1:0] x_o     [2];
    logic         yr      [2];
    logic         yd      [2];
    logic         busy_o  [2];
    logic         done_o  [2];
    logic [N:0]   mm_o    [2];
    logic [N:0]   on_o    [2];
    logic [N-1:0] fi_o    [2];
    logic         fv_o    [2];
    logic         eq_o    [2];

    logic [V-1:0] ref_tt;
    logic [V-1:0] dut_tt;

    int checks   = 0;
    int failures = 0;

    pla_sweep_ctrl #(.N_IN(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .x_out(x_o[0]), .y_ref(yr[0]), .y_dut(yd[0]),
        .busy(busy_o[0]), .done(done_o[0]), .mismatch_cnt(mm_o[0]),
        .onset_cnt(on_o[0]), .first_mm_idx(fi_o[0]),
        .first_mm_valid(fv_o[0]), .equal(eq_o[0])
    );

    pla_sweep_ctrl #(.N_IN(N), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .x_out(x_o[1]), .y_ref(yr[1]), .y_dut(yd[1]),
        .busy(busy_o[1]), .done(done_o[1]), .mismatch_cnt(mm_o[1]),
        .onset_cnt(on_o[1]), .first_mm_idx(fi_o[1]),
        .first_mm_valid(fv_o[1]), .equal(eq_o[1])
    );

    always #5 clk = ~clk;

    // Both functions are pure table lookups on the applied vector.
    always_comb begin
        yr[0] = ref_tt[x_o[0]];
        yd[0] = dut_tt[x_o[0]];
        yr[1] = ref_tt[x_o[1]];
        yd[1] = dut_tt[x_o[1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference statistics by enumerating every vector of the tables.
    task automatic model(output int mm, output int on, output int fi, output int fv);
        mm = 0; on = 0; fi = 0; fv = 0;
        for (int i = 0; i < V; i++) begin
            if (ref_tt[i]) on++;
            if (ref_tt[i] != dut_tt[i]) begin
                if (mm == 0) begin
                    fi = i;
                    fv = 1;
                end
                mm++;
            end
        end
    endtask

    task automatic random_tables(input int flip_mod);
        for (int i = 0; i < V; i++) begin
            ref_tt[i] = 1'($urandom_range(0, 1));
            dut_tt[i] = ref_tt[i] ^ (flip_mod > 0 && $urandom_range(0, flip_mod - 1) == 0);
        end
    endtask

    // Full sweep from IDLE or DONE; optional random start noise while running.
    task automatic sweep(input int d, input int s, input bit noise);
        int len;
        int bad;
        int emm, eon, efi, efv;
        len = V * (s + 1);
        bad = 0;
        model(emm, eon, efi, efv);
        @(negedge clk);
        start_s[d] = 1'b1;
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            start_s[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (x_o[d] !== N'((n - 1) / (s + 1)) || busy_o[d] !== 1'b1 || done_o[d] !== 1'b0)
                bad++;
        end
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("run_sequence_errors", bad, 0);
        chk("done_after_sweep", done_o[d], 1);
        chk("busy_after_sweep", busy_o[d], 0);
        chk("x_held_last", x_o[d], V - 1);
        chk("mismatch_cnt", mm_o[d], emm);
        chk("onset_cnt", on_o[d], eon);
        chk("first_mm_valid", fv_o[d], efv);
        chk("first_mm_idx", fi_o[d], efi);
        chk("equal", eq_o[d], (emm == 0) ? 1 : 0);
    endtask

    // Start a sweep, then abort while vector xa is applied (optionally with start).
    task automatic abort_at(input int d, input int s, input int xa, input bit with_start);
        int target;
        target = xa * (s + 1) + 1 + ((s > 0) ? 1 : 0);
        @(negedge clk);
        start_s[d] = 1'b1;
        for (int n = 1; n <= target; n++) begin
            @(negedge clk);
            start_s[d] = 1'b0;
        end
        chk("x_before_abort", x_o[d], xa);
        abort_s[d] = 1'b1;
        start_s[d] = with_start;
        @(negedge clk);
        abort_s[d] = 1'b0;
        start_s[d] = 1'b0;
        chk("abort_busy", busy_o[d], 0);
        chk("abort_done", done_o[d], 0);
        chk("abort_x", x_o[d], 0);
        chk("abort_equal", eq_o[d], 0);
        repeat (3) @(negedge clk);
        chk("no_queued_start", busy_o[d], 0);
        abort_s[d] = 1'b1;
        @(negedge clk);
        abort_s[d] = 1'b0;
        chk("abort_in_idle_x", x_o[d], 0);
    endtask

    task automatic check_all_zero(input int d);
        chk("rst_x", x_o[d], 0);
        chk("rst_busy", busy_o[d], 0);
        chk("rst_done", done_o[d], 0);
        chk("rst_mm", mm_o[d], 0);
        chk("rst_on", on_o[d], 0);
        chk("rst_fi", fi_o[d], 0);
        chk("rst_fv", fv_o[d], 0);
        chk("rst_equal", eq_o[d], 0);
    endtask

    initial begin
        rst = 1'b1;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        abort_s[0] = 1'b0; abort_s[1] = 1'b0;
        ref_tt = '1;
        dut_tt = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero(0);
        check_all_zero(1);

        // Identical constant-1 functions.
        sweep(0, 0, 1'b0);

        // DONE holds through abort.
        abort_s[0] = 1'b1;
        repeat (3) @(negedge clk);
        abort_s[0] = 1'b0;
        chk("done_hold_abort", done_o[0], 1);
        chk("onset_hold", on_o[0], V);

        // Complementary functions, restart from DONE.
        for (int i = 0; i < V; i++) begin
            ref_tt[i] = 1'(i & 1);
            dut_tt[i] = ~ref_tt[i];
        end
        sweep(0, 0, 1'b0);

        // Single difference at 7'h55.
        ref_tt = '0;
        ref_tt[V - 1] = 1'b1;
        dut_tt = ref_tt;
        dut_tt[7'h55] = 1'b1;
        sweep(0, 0, 1'b0);

        // Settle time 3 with identical functions.
        ref_tt = '1;
        dut_tt = '1;
        sweep(1, 3, 1'b0);

        // Abort at x=40, then a noisy restart with random tables.
        abort_at(0, 0, 40, 1'b0);
        random_tables(16);
        sweep(0, 0, 1'b1);

        // Abort with simultaneous start on the settling instance.
        abort_at(1, 3, 40, 1'b1);
        random_tables(0);
        sweep(1, 3, 1'b1);

        // Reset mid-sweep clears everything.
        @(negedge clk);
        start_s[0] = 1'b1;
        repeat (41) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        chk("x_before_rst", x_o[0], 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(0);
        check_all_zero(1);

        // Random tables on both instances.
        for (int k = 0; k < 4; k++) begin
            random_tables((k == 3) ? 0 : 8 * (k + 1));
            sweep(k & 1, (k & 1) * 3, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
